gin_feeder: RTL and testbench

GIN_FEEDER -- requirements
Module: gin_feeder

---
 rtl/gin_feeder_if.sv | 28 ++
 rtl/gin_feeder.sv | 158 +++++++++++++++
 tb/tb_gin_feeder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gin_feeder_if.sv
// GIN output channel of gin_feeder: valid/ready handshake with payload and X/Y tags.
interface gin_feeder_if #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned XID_BITS  = 5,
  parameter int unsigned YID_BITS  = 4
) ();
  logic                 GIN_valid;
  logic                 GIN_ready;
  logic [DATA_BITS-1:0] GIN_data;
  logic [XID_BITS-1:0]  tag_X;
  logic [YID_BITS-1:0]  tag_Y;

  modport master (
    output GIN_valid,
    input  GIN_ready,
    output GIN_data,
    output tag_X,
    output tag_Y
  );

  modport slave (
    input  GIN_valid,
    output GIN_ready,
    input  GIN_data,
    input  tag_X,
    input  tag_Y
  );
endinterface

// File: rtl/gin_feeder.sv
// Streams a run of buffer-SRAM words onto the GIN with X/Y tags through a 2-entry FIFO.
// Optional stall counter output enabled by defining GIN_FEEDER_PERF_EN.
module gin_feeder #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned XID_BITS  = 5,
  parameter int unsigned YID_BITS  = 4,
  parameter int unsigned LEN_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  length,
  input  logic [LEN_BITS-1:0]  row_len,
  input  logic [XID_BITS-1:0]  tag_x0,
  input  logic [YID_BITS-1:0]  tag_y0,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_en,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_BITS-1:0] sram_rdata,
  gin_feeder_if.master         gin
`ifdef GIN_FEEDER_PERF_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]  len_q, row_len_q, issue_cnt_q, accept_cnt_q, row_cnt_q;
  logic [XID_BITS-1:0]  x0_q, x_q, x_pend_q;
  logic [YID_BITS-1:0]  y_q, y_pend_q;
  logic                 rd_pend_q, done_zero_q;
  logic                 wr_ptr_q, rd_ptr_q;
  logic [1:0]           count_q;

  logic [DATA_BITS-1:0] mem_data [2];
  logic [XID_BITS-1:0]  mem_x [2];
  logic [YID_BITS-1:0]  mem_y [2];

  logic       valid, push, pop, last_accept, row_last;
  logic [2:0] occ_next;

  assign valid       = (count_q != 2'd0);
  assign push        = rd_pend_q;
  assign pop         = valid & gin.GIN_ready;
  assign row_last    = (row_cnt_q == row_len_q - LEN_BITS'(1));
  assign last_accept = (state_q == StDrain) && pop && (accept_cnt_q == len_q - LEN_BITS'(1));

  // Occupancy after this cycle's pop plus the read in flight; a same-cycle pop frees a
  // slot so back-to-back reads sustain one word per cycle without overflowing the FIFO.
  assign occ_next = {1'b0, count_q} - {2'b00, pop} + {2'b00, rd_pend_q};

  assign sram_en   = (state_q == StRun) && (occ_next < 3'd2);
  assign sram_addr = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_zero_q | last_accept;

  assign gin.GIN_valid = valid;
  assign gin.GIN_data  = valid ? mem_data[rd_ptr_q] : '0;
  assign gin.tag_X     = valid ? mem_x[rd_ptr_q]    : '0;
  assign gin.tag_Y     = valid ? mem_y[rd_ptr_q]    : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      row_len_q    <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      row_cnt_q    <= '0;
      x0_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      x_pend_q     <= '0;
      y_pend_q     <= '0;
      rd_pend_q    <= 1'b0;
      done_zero_q  <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      done_zero_q <= 1'b0;
      rd_pend_q   <= sram_en;
      case (state_q)
        StIdle: begin
          if (start) begin
            addr_q       <= base_addr;
            len_q        <= length;
            row_len_q    <= (row_len == '0) ? LEN_BITS'(1) : row_len;
            x0_q         <= tag_x0;
            x_q          <= tag_x0;
            y_q          <= tag_y0;
            issue_cnt_q  <= '0;
            accept_cnt_q <= '0;
            row_cnt_q    <= '0;
            if (length != '0) state_q <= StRun;
            else              done_zero_q <= 1'b1;
          end
        end
        StRun: begin
          if (sram_en) begin
            addr_q      <= addr_q + ADDR_BITS'(1);
            issue_cnt_q <= issue_cnt_q + LEN_BITS'(1);
            x_pend_q    <= x_q;
            y_pend_q    <= y_q;
            if (row_last) begin
              row_cnt_q <= '0;
              x_q       <= x0_q;
              y_q       <= y_q + YID_BITS'(1);
            end else begin
              row_cnt_q <= row_cnt_q + LEN_BITS'(1);
              x_q       <= x_q + XID_BITS'(1);
            end
            if (issue_cnt_q == len_q - LEN_BITS'(1)) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (last_accept) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q     <= ~rd_ptr_q;
        accept_cnt_q <= accept_cnt_q + LEN_BITS'(1);
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= sram_rdata;
      mem_x[wr_ptr_q]    <= x_pend_q;
      mem_y[wr_ptr_q]    <= y_pend_q;
    end
  end

`ifdef GIN_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_cnt <= '0;
    end else if (valid && !gin.GIN_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gin_feeder.sv
// Directed self-checking bench for gin_feeder with a 1-cycle-latency SRAM model.
module tb_gin_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [11:0] length = '0;
  logic [11:0] row_len = '0;
  logic [4:0]  tag_x0 = '0;
  logic [3:0]  tag_y0 = '0;
  logic        busy, done, sram_en;
  logic [11:0] sram_addr;
  logic [31:0] sram_rdata = '0;
`ifdef GIN_FEEDER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  gin_feeder_if #(.DATA_BITS(32), .XID_BITS(5), .YID_BITS(4)) gin ();

  gin_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .row_len    (row_len),
    .tag_x0     (tag_x0),
    .tag_y0     (tag_y0),
    .busy       (busy),
    .done       (done),
    .sram_en    (sram_en),
    .sram_addr  (sram_addr),
    .sram_rdata (sram_rdata),
    .gin        (gin)
`ifdef GIN_FEEDER_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data is valid only in the cycle after the read; otherwise a poison value.
  always @(posedge clk) sram_rdata <= sram_en ? (32'hD000_0000 | 32'(sram_addr)) : 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor state, sampled on the falling edge.
  logic [11:0] rd_q[$];
  logic [40:0] acc_q[$];
  int n_done, done_cyc, done_acc, first_valid_cyc, busy_cycles, unstable, max_out, start_cyc;
  logic        prev_stall;
  logic [40:0] prev_head;

  task automatic clear_mon();
    rd_q.delete();
    acc_q.delete();
    n_done = 0; done_cyc = -1; done_acc = -1; first_valid_cyc = -1;
    busy_cycles = 0; unstable = 0; max_out = 0; prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [40:0] head;
    head = {gin.GIN_data, gin.tag_X, gin.tag_Y};
    if (sram_en) rd_q.push_back(sram_addr);
    if (busy) busy_cycles++;
    if (gin.GIN_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (gin.GIN_valid && !gin.GIN_ready) begin
      if (prev_stall && head !== prev_head) unstable++;
      prev_stall = 1'b1;
      prev_head  = head;
    end else begin
      prev_stall = 1'b0;
    end
    if (gin.GIN_valid && gin.GIN_ready) acc_q.push_back(head);
    if (done) begin
      n_done++;
      done_cyc = cyc;
      done_acc = acc_q.size();
    end
    if (rd_q.size() - acc_q.size() > max_out) max_out = rd_q.size() - acc_q.size();
  end

  task automatic issue(input logic [11:0] b, input logic [11:0] l, input logic [11:0] rl,
                       input logic [4:0] x, input logic [3:0] y);
    @(posedge clk); #1;
    base_addr = b; length = l; row_len = rl; tag_x0 = x; tag_y0 = y;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n_done == 0) check("done_timeout", 64'd0, 64'd1);
    repeat (3) @(posedge clk);
  endtask

  function automatic logic [40:0] word(input logic [11:0] a, input logic [4:0] x,
                                       input logic [3:0] y);
    return {32'hD000_0000 | 32'(a), x, y};
  endfunction

  initial begin
    logic [11:0] wrap_exp [3];
    wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000;
    clear_mon();
    gin.GIN_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, sram_en, gin.GIN_valid, sram_addr,
                            gin.GIN_data, gin.tag_X, gin.tag_Y}, 64'd0);
    rst = 1'b0;

    // Basic run, ready held high.
    clear_mon();
    issue(12'h010, 12'd4, 12'd2, 5'd3, 4'd1);
    wait_done(50);
    check("basic_count", 64'(acc_q.size()), 64'd4);
    check("basic_w0", acc_q[0], word(12'h010, 5'd3, 4'd1));
    check("basic_w1", acc_q[1], word(12'h011, 5'd4, 4'd1));
    check("basic_w2", acc_q[2], word(12'h012, 5'd3, 4'd2));
    check("basic_w3", acc_q[3], word(12'h013, 5'd4, 4'd2));
    check("basic_reads", 64'(rd_q.size()), 64'd4);
    // Start is captured at edge start_cyc+1; first valid two edges later.
    check("first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("basic_done_once", 64'(n_done), 64'd1);
    check("done_with_4th", 64'(done_acc), 64'd4);
    check("basic_idle", 64'(busy), 64'd0);

    // Backpressure for 5 cycles from the first valid word.
    clear_mon();
    gin.GIN_ready = 1'b0;
    issue(12'h010, 12'd4, 12'd2, 5'd3, 4'd1);
    begin
      int n = 0;
      while (first_valid_cyc < 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (first_valid_cyc < 0) check("stall_valid_timeout", 64'd0, 64'd1);
    end
    repeat (4) @(posedge clk);
    #1 gin.GIN_ready = 1'b1;
    wait_done(50);
    check("stall_head_stable", 64'(unstable), 64'd0);
    check("stall_outstanding", 64'(max_out > 2), 64'd0);
    check("stall_count", 64'(acc_q.size()), 64'd4);
    check("stall_w0", acc_q[0], word(12'h010, 5'd3, 4'd1));
    check("stall_w1", acc_q[1], word(12'h011, 5'd4, 4'd1));
    check("stall_w2", acc_q[2], word(12'h012, 5'd3, 4'd2));
    check("stall_w3", acc_q[3], word(12'h013, 5'd4, 4'd2));
    check("stall_done_once", 64'(n_done), 64'd1);
`ifdef GIN_FEEDER_PERF_EN
    check("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Zero-length command.
    clear_mon();
    issue(12'h055, 12'd0, 12'd1, 5'd0, 4'd0);
    repeat (5) @(posedge clk);
    check("len0_no_read", 64'(rd_q.size()), 64'd0);
    check("len0_no_busy", 64'(busy_cycles), 64'd0);
    check("len0_done_once", 64'(n_done), 64'd1);
    check("len0_done_cycle", 64'(done_cyc - start_cyc), 64'd1);

    // Address wrap.
    clear_mon();
    issue(12'hFFE, 12'd3, 12'd0, 5'd0, 4'd0);
    wait_done(50);
    check("wrap_reads", 64'(rd_q.size()), 64'd3);
    for (int i = 0; i < 3; i++) check($sformatf("wrap_addr%0d", i), 64'(rd_q[i]), 64'(wrap_exp[i]));
    // row_len=0 behaves as 1: tag_Y steps every word.
    check("wrap_w2", acc_q[2], word(12'h000, 5'd0, 4'd2));

    // Reset in the middle of a 6-word transfer.
    clear_mon();
    issue(12'h040, 12'd6, 12'd6, 5'd0, 4'd0);
    begin
      int n = 0;
      while (acc_q.size() < 2 && n < 30) begin
        @(posedge clk);
        n++;
      end
      if (acc_q.size() < 2) check("midrst_timeout", 64'd0, 64'd1);
    end
    #1 rst = 1'b1;
    #1;
    check("midrst_outputs", {busy, done, sram_en, gin.GIN_valid, sram_addr,
                             gin.GIN_data, gin.tag_X, gin.tag_Y}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    check("midrst_no_stale", 64'(acc_q.size() + n_done), 64'd0);
    issue(12'h100, 12'd1, 12'd1, 5'd7, 4'd2);
    wait_done(50);
    check("midrst_new_count", 64'(acc_q.size()), 64'd1);
    check("midrst_new_w0", acc_q[0], word(12'h100, 5'd7, 4'd2));

    // Second start while busy must be ignored.
    clear_mon();
    issue(12'h020, 12'd3, 12'd3, 5'd1, 4'd0);
    issue(12'h300, 12'd5, 12'd1, 5'd9, 4'd9);
    wait_done(50);
    repeat (5) @(posedge clk);
    check("restart_count", 64'(acc_q.size()), 64'd3);
    check("restart_w0", acc_q[0], word(12'h020, 5'd1, 4'd0));
    check("restart_w1", acc_q[1], word(12'h021, 5'd2, 4'd0));
    check("restart_w2", acc_q[2], word(12'h022, 5'd3, 4'd0));
    check("restart_done_once", 64'(n_done), 64'd1);
    check("restart_reads", 64'(rd_q.size()), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
